simon_sequencer: RTL
====================

# simon_sequencer

Game controller for the Simon Says display path. Generates a pseudo-random colour sequence, plays it back one step at a time as a one-hot colour on `color`, then checks the player's KEY presses against it. The sequence grows by one step each round until the level target is reached (win), a wrong key is pressed, or the player times out (lose). `state` and `color` drive the grid renderer and seven-segment decoders directly, replacing the SW-driven state and KEY-driven colour.

## Interface
- `MAX_LEN`, 20: sequence storage depth in steps; must be at least 4×5.
- `TICKS_ON`, 25_000_000: cycles each playback colour is lit (0.5 s at 50 MHz).
- `TICKS_OFF`, 12_500_000: dark gap after each playback colour.
- `TICKS_TIMEOUT`, 250_000_000: maximum cycles allowed between player presses.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR; must be non-zero.
- `CLOCK_50` in 1: the single clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sensitive. Begins a game from IDLE, WIN or LOSE.
- `level` in 3: difficulty, sampled only when a game starts.
- `key_n` in 4: raw KEY[3:0], active-low, asynchronous.
- `state` out 2: 00 idle, 01 game playback, 10 user input, 11 done.
- `color` out 4: one-hot lit colour; 0000 means dark.
- `round` out 5: current sequence length.
- `win` out 1, `lose` out 1: result flags, valid while in state 11.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every cycle, including in IDLE. Reset loads `LFSR_SEED`.
- **Sequence storage:** `MAX_LEN` × 2-bit register array `seq`. Colour code c maps to one-hot `1<<c`.
- **Target length:** set when the game starts, as 4×`level`. `level` 0 is treated as 1; `level` 6 or 7 is treated as 5.
- **Key input:** `~key_n` passes through a 2-flop synchronizer to `ks`, with a 1-cycle delayed copy `kp`.
  - A press event is `kp==0` and `ks` exactly one-hot.
  - Multi-key states and held keys produce no event.
- **FSM states:** IDLE, ADD, PLAY_ON, PLAY_OFF, USER, WIN, LOSE.
  - **IDLE** (`state` 00): `color`=0, `round`=0. On `start`: latch the target, set `len`=0, go to ADD.
  - **ADD** (one cycle, `state` 01): `seq[len]` ← `lfsr[1:0]`, `len` ← `len`+1, `idx` ← 0, timer ← 0, go to PLAY_ON.
  - **PLAY_ON** (`state` 01): `color` = one-hot of `seq[idx]` for exactly `TICKS_ON` cycles, then go to PLAY_OFF.
  - **PLAY_OFF** (`state` 01): `color`=0 for `TICKS_OFF` cycles.
    - Then, if `idx==len-1`: go to USER with `idx`=0 and timer=0.
    - Otherwise: `idx`++ and go to PLAY_ON.
  - **USER** (`state` 10): `color` = `ks` when `ks` is one-hot, else 0 (echo of the held key). On a press event:
    - Mismatch with `seq[idx]`: go to LOSE.
    - Match and `idx<len-1`: `idx`++, timer ← 0.
    - Match and `idx==len-1` and `len==target`: go to WIN.
    - Match and `idx==len-1` and `len<target`: go to PLAY_OFF with timer=0 (a gap before the next round), then to ADD. Route this as a flag that makes PLAY_OFF exit to ADD.
    - Timeout: timer reaching `TICKS_TIMEOUT-1` with no press goes to LOSE. A press in the same cycle as the timeout wins over the timeout.
  - **WIN / LOSE** (`state` 11): `color`=0, `win`/`lose` held at 1.
    - On `start`: clear both flags, latch a new target, set `len`=0, go to ADD.
    - Keep `start` held to chain games: WIN/LOSE last at least one cycle.
- **Reset** at any point: IDLE, `len`=0, `idx`=0, timers=0, all outputs 0, LFSR reloaded. Stale `seq` contents are not cleared and are never read before being rewritten.
- **`round`** = `len`, zero-extended. `len` never exceeds 20, so there is no wrap.

## Timing
- All outputs are registered and update on the rising edge of `CLOCK_50`.
- Reset values: `state`=00, `color`=0000, `round`=0, `win`=0, `lose`=0.
- `start` high at edge n moves the FSM to ADD at n+1 and PLAY_ON at n+2. `color` is valid from n+2.
- PLAY_ON lasts exactly `TICKS_ON` cycles and PLAY_OFF exactly `TICKS_OFF` cycles. One full playback step is `TICKS_ON+TICKS_OFF`.
- Key latency: a `key_n` change sampled at edge n reaches `ks` at n+2. The resulting state or `idx` update is visible at n+3.
- The USER timer restarts on entry to USER and after each accepted press.

## Test plan
Bench parameters: `TICKS_ON`=4, `TICKS_OFF`=2, `TICKS_TIMEOUT`=40.

- **Reset, then idle:** reset, release, idle 10 cycles with `start`=0 -> `state`=00, `color`=0, `round`=0, flags 0.
- **First round playback:** `start` pulse with `level`=1 -> `round`=1 at n+2, `color` = one-hot(`LFSR_SEED`-derived value) for 4 cycles, 0 for 2 cycles, then `state`=10.
- **Full win at level 1:** echo each played colour with correct single-key presses -> `round` steps 1,2,3,4, then `state`=11, `win`=1, `lose`=0.
- **Wrong key:** in round 2, press a colour different from `seq[0]` -> `state`=11, `lose`=1 three cycles after the press; `round` stays 2.
- **Timeout and multi-key:** in USER, hold two keys, then press nothing -> no event or echo; `lose`=1 exactly 40 cycles after USER entry.
- **Reset mid-playback, then level clamp:** assert reset during PLAY_ON -> all outputs 0 next cycle. Then start with `level`=7 -> the win occurs only at `round`=20.

Source files
------------

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon Says game controller.
// Builds a pseudo-random colour sequence, plays it back one step at a time as
// a one-hot colour, then checks the player's key presses against it. Each
// correct round adds one step until the level target is reached (win). A
// wrong key or a timeout ends the game (lose).
module simon_sequencer #(
  parameter int          MAX_LEN       = 20,
  parameter int          TICKS_ON      = 25_000_000,
  parameter int          TICKS_OFF     = 12_500_000,
  parameter int          TICKS_TIMEOUT = 250_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [3:0] key_n,
  output logic [1:0] state,
  output logic [3:0] color,
  output logic [4:0] round,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_USER,
    S_WIN,
    S_LOSE
  } fsm_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_USER = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [31:0] ON_LAST  = 32'(TICKS_ON - 1);
  localparam logic [31:0] OFF_LAST = 32'(TICKS_OFF - 1);
  localparam logic [31:0] TO_LAST  = 32'(TICKS_TIMEOUT - 1);

  fsm_t        fsm;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [1:0]  seq [MAX_LEN];
  logic [4:0]  len;
  logic [4:0]  idx;
  logic [4:0]  idx_next;
  logic [4:0]  target;
  logic [4:0]  target_new;
  logic [2:0]  lvl;
  logic [31:0] timer;
  logic        next_add;
  logic        last_step;

  logic [3:0]  sync1;
  logic [3:0]  ks;
  logic [3:0]  kp;
  logic        ks_onehot;
  logic [1:0]  ks_code;
  logic        press;
  logic        press_match;

  // The colour code c lights the lamp 1<<c.
  function automatic logic [3:0] code_to_onehot(input logic [1:0] c);
    code_to_onehot = 4'b0001 << c;
  endfunction

  assign round = len;

  // Left-shifting Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // LFSR free-runs every cycle so the sequence depends on when start arrives.
  always_ff @(posedge CLOCK_50) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Two-flop synchronizer for the active-low keys, plus a delayed copy for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 4'd0;
      ks    <= 4'd0;
      kp    <= 4'd0;
    end else begin
      sync1 <= ~key_n;
      ks    <= sync1;
      kp    <= ks;
    end
  end

  assign ks_onehot = (ks == 4'b0001) || (ks == 4'b0010) ||
                     (ks == 4'b0100) || (ks == 4'b1000);

  // A press only counts when coming from no keys to exactly one key.
  assign press = (kp == 4'd0) && ks_onehot;

  // Encode the single held key back into a colour code.
  always_comb begin
    ks_code = 2'd0;
    case (ks)
      4'b0010: ks_code = 2'd1;
      4'b0100: ks_code = 2'd2;
      4'b1000: ks_code = 2'd3;
      default: ks_code = 2'd0;
    endcase
  end

  assign press_match = (ks_code == seq[idx]);
  assign last_step   = (idx == len - 5'd1);
  assign idx_next    = idx + 5'd1;

  // Level 0 plays as level 1 and levels above 5 play as level 5; four steps per level.
  always_comb begin
    lvl = level;
    if (level == 3'd0)      lvl = 3'd1;
    else if (level > 3'd5)  lvl = 3'd5;
  end

  assign target_new = {lvl, 2'b00};

  // Sequence storage is only written while adding a step; reset leaves old contents behind.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && fsm == S_ADD) seq[len] <= lfsr[1:0];
  end

  // Game FSM with registered state, colour and result outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fsm      <= S_IDLE;
      len      <= 5'd0;
      idx      <= 5'd0;
      timer    <= 32'd0;
      target   <= 5'd0;
      next_add <= 1'b0;
      state    <= ST_IDLE;
      color    <= 4'd0;
      win      <= 1'b0;
      lose     <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          state <= ST_IDLE;
          color <= 4'd0;
          if (start) begin
            target <= target_new;
            len    <= 5'd0;
            fsm    <= S_ADD;
            state  <= ST_PLAY;
          end
        end

        S_ADD: begin
          len   <= len + 5'd1;
          idx   <= 5'd0;
          timer <= 32'd0;
          fsm   <= S_PLAY_ON;
          state <= ST_PLAY;
          // Step 0 is the value being written right now when the sequence is empty.
          color <= (len == 5'd0) ? code_to_onehot(lfsr[1:0]) : code_to_onehot(seq[0]);
        end

        S_PLAY_ON: begin
          if (timer == ON_LAST) begin
            timer <= 32'd0;
            color <= 4'd0;
            fsm   <= S_PLAY_OFF;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_PLAY_OFF: begin
          if (timer == OFF_LAST) begin
            timer <= 32'd0;
            if (next_add) begin
              next_add <= 1'b0;
              fsm      <= S_ADD;
            end else if (last_step) begin
              idx   <= 5'd0;
              fsm   <= S_USER;
              state <= ST_USER;
              color <= 4'd0;
            end else begin
              idx   <= idx_next;
              color <= code_to_onehot(seq[idx_next]);
              fsm   <= S_PLAY_ON;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_USER: begin
          color <= ks_onehot ? ks : 4'd0;
          if (press) begin
            if (!press_match) begin
              fsm   <= S_LOSE;
              state <= ST_DONE;
              color <= 4'd0;
              lose  <= 1'b1;
            end else if (!last_step) begin
              idx   <= idx_next;
              timer <= 32'd0;
            end else if (len == target) begin
              fsm   <= S_WIN;
              state <= ST_DONE;
              color <= 4'd0;
              win   <= 1'b1;
            end else begin
              next_add <= 1'b1;
              timer    <= 32'd0;
              color    <= 4'd0;
              fsm      <= S_PLAY_OFF;
              state    <= ST_PLAY;
            end
          end else if (timer == TO_LAST) begin
            fsm   <= S_LOSE;
            state <= ST_DONE;
            color <= 4'd0;
            lose  <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_WIN, S_LOSE: begin
          color <= 4'd0;
          state <= ST_DONE;
          if (start) begin
            win    <= 1'b0;
            lose   <= 1'b0;
            target <= target_new;
            len    <= 5'd0;
            fsm    <= S_ADD;
            state  <= ST_PLAY;
          end
        end

        default: begin
          fsm   <= S_IDLE;
          state <= ST_IDLE;
          color <= 4'd0;
        end
      endcase
    end
  end

endmodule
